// File: rtl/ctrl_valvula_rega.sv
// Irrigation valve sequencer: drives the 2-bit valve-position counter
// (0=closed, 3=fully open) from soil/tank sensors, paces counter steps,
// supervises counter feedback and latches a safe closed state on fault.
module ctrl_valvula_rega #(
    parameter int STEP_CYCLES  = 8,
    parameter int REGA_CYCLES  = 1000,
    parameter int PAUSA_CYCLES = 100,
    parameter int TW           = 16
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Seco,
    input  logic       Umido,
    input  logic       NivelBaixo,
    input  logic [1:0] Q,
    output logic       Y,
    output logic       Step,
    output logic       Pos0,
    output logic       Pos3,
    output logic       Regando,
    output logic       Alarme,
    output logic [2:0] Estado
);

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_IDLE   = 3'd1,
        ST_ABRE   = 3'd2,
        ST_REGA   = 3'd3,
        ST_FECHA  = 3'd4,
        ST_ALARME = 3'd5
    } state_t;

    // Step period counts down to zero, so the reload is one less than the period.
    localparam logic [TW-1:0] STEP_RELOAD = TW'(STEP_CYCLES - 1);
    localparam logic [TW-1:0] REGA_LOAD   = TW'(REGA_CYCLES);
    localparam logic [TW-1:0] PAUSA_LOAD  = TW'(PAUSA_CYCLES);
    localparam logic [2:0]    MAX_STEPS   = 3'd5;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    step_cnt_q, step_cnt_d;
    logic          step_fire;
    logic          y_q, y_d;
    logic          step_q, step_d;
    logic          pos0_q, pos0_d;
    logic          regando_q, regando_d;
    logic          alarme_q, alarme_d;

    // Next-state logic; one shared timer serves pause, irrigation and step pacing.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        step_cnt_d = step_cnt_q;
        step_fire  = 1'b0;
        case (state_q)
            ST_INIT: begin
                state_d = ST_IDLE;
                timer_d = PAUSA_LOAD;
            end
            ST_IDLE: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - 1'b1;
                end
                // Seco together with Umido is a sensor conflict: just keep waiting.
                if ((timer_q == '0) && Seco && !Umido && !NivelBaixo) begin
                    state_d    = ST_ABRE;
                    timer_d    = STEP_RELOAD;
                    step_cnt_d = '0;
                end
            end
            ST_ABRE: begin
                // Low tank wins over any pending step; feedback is only trusted
                // on cycles where the counter is not being advanced.
                if (NivelBaixo) begin
                    state_d    = ST_FECHA;
                    timer_d    = STEP_RELOAD;
                    step_cnt_d = '0;
                end else if (!step_q && (Q == 2'd3)) begin
                    state_d = ST_REGA;
                    timer_d = REGA_LOAD;
                end else if (!step_q && (step_cnt_q >= MAX_STEPS)) begin
                    state_d = ST_ALARME;
                end else if (timer_q == '0) begin
                    step_fire  = 1'b1;
                    timer_d    = STEP_RELOAD;
                    step_cnt_d = step_cnt_q + 3'd1;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_REGA: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - 1'b1;
                end
                // Leave on the cycle the timer would hit zero, so REGA lasts
                // exactly REGA_CYCLES cycles.
                if (Umido || NivelBaixo || (timer_q <= TW'(1))) begin
                    state_d    = ST_FECHA;
                    timer_d    = STEP_RELOAD;
                    step_cnt_d = '0;
                end
            end
            ST_FECHA: begin
                // Sensors are deliberately ignored here: closing always completes.
                if (!step_q && (Q == 2'd0)) begin
                    state_d = ST_IDLE;
                    timer_d = PAUSA_LOAD;
                end else if (!step_q && (step_cnt_q >= MAX_STEPS)) begin
                    state_d = ST_ALARME;
                end else if (timer_q == '0) begin
                    step_fire  = 1'b1;
                    timer_d    = STEP_RELOAD;
                    step_cnt_d = step_cnt_q + 3'd1;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_ALARME: begin
                state_d = ST_ALARME;
            end
            default: begin
                state_d = ST_ALARME;
            end
        endcase
    end

    // Output decode from the next state so every output is a flop.
    always_comb begin
        y_d       = (state_d == ST_ABRE);
        step_d    = step_fire;
        pos0_d    = (state_q == ST_INIT) || (state_d == ST_ALARME);
        regando_d = (state_d == ST_REGA);
        alarme_d  = alarme_q || (state_d == ST_ALARME);
    end

    // State, timer, step counter and registered outputs.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= ST_INIT;
            timer_q    <= '0;
            step_cnt_q <= '0;
            y_q        <= 1'b0;
            step_q     <= 1'b0;
            pos0_q     <= 1'b0;
            regando_q  <= 1'b0;
            alarme_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            step_cnt_q <= step_cnt_d;
            y_q        <= y_d;
            step_q     <= step_d;
            pos0_q     <= pos0_d;
            regando_q  <= regando_d;
            alarme_q   <= alarme_d;
        end
    end

    assign Y       = y_q;
    assign Step    = step_q;
    assign Pos0    = pos0_q;
    assign Pos3    = 1'b0;
    assign Regando = regando_q;
    assign Alarme  = alarme_q;
    assign Estado  = state_q;

endmodule

// File: tb/tb_ctrl_valvula_rega.sv
// Directed bench for ctrl_valvula_rega with a behavioural position counter
// that follows Step/Y/Pos0 and can be made to stick at position 1.
module tb_ctrl_valvula_rega;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       Seco = 1'b0;
    logic       Umido = 1'b0;
    logic       NivelBaixo = 1'b0;
    logic [1:0] q_model;
    logic       Y, Step, Pos0, Pos3, Regando, Alarme;
    logic [2:0] Estado;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit stuck = 1'b0;
    int step_cyc[$];
    bit step_y[$];

    ctrl_valvula_rega dut (
        .Clk(Clk), .Rst(Rst), .Seco(Seco), .Umido(Umido),
        .NivelBaixo(NivelBaixo), .Q(q_model), .Y(Y), .Step(Step),
        .Pos0(Pos0), .Pos3(Pos3), .Regando(Regando), .Alarme(Alarme),
        .Estado(Estado)
    );

    always #5 Clk = ~Clk;

    // Position counter model
    always @(posedge Clk) begin
        if (Rst || Pos0) q_model <= 2'd0;
        else if (Pos3) q_model <= 2'd3;
        else if (Step && !(stuck && q_model == 2'd1))
            q_model <= Y ? q_model + 2'd1 : q_model - 2'd1;
    end

    // Step log and Step/Pos0 exclusion monitor
    always @(negedge Clk) begin
        cyc++;
        if (Step) begin
            step_cyc.push_back(cyc);
            step_y.push_back(Y);
        end
        if (Step || Pos0) begin
            total++;
            if (Step && Pos0) begin
                bad++;
                $display("FAIL step_pos0_excl: Step=%b Pos0=%b required not both 1", Step, Pos0);
            end
        end
    end

    task automatic cyc1();
        @(negedge Clk);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] s, input int max, output int n);
        n = 0;
        while (Estado !== s && n < max) begin
            cyc1();
            n++;
        end
    endtask

    task automatic apply_reset();
        Rst = 1'b1;
        cyc1();
        cyc1();
        Rst = 1'b0;
    endtask

    task automatic clear_log();
        step_cyc.delete();
        step_y.delete();
    endtask

    task automatic test_reset();
        int n;
        Rst = 1'b1;
        Seco = 1'b1;
        cyc1();
        cyc1();
        total++;
        if ({Estado, Y, Step, Pos0, Pos3, Regando, Alarme} !== 9'b000_000000) begin
            bad++;
            $display("FAIL reset_state: Estado=%0d Y%bS%bP0%bP3%bR%bA%b required 0 all", Estado, Y, Step, Pos0, Pos3, Regando, Alarme);
        end
        Rst = 1'b0;
        cyc1();
        total++;
        if (Estado !== 3'd1 || Pos0 !== 1'b1 || Y !== 1'b0 || Step !== 1'b0 || Alarme !== 1'b0) begin
            bad++;
            $display("FAIL init_pos0: Estado=%0d Pos0=%b Y=%b Step=%b required 1,1,0,0", Estado, Pos0, Y, Step);
        end
        cyc1();
        total++;
        if (Estado !== 3'd1 || Pos0 !== 1'b0) begin
            bad++;
            $display("FAIL pos0_one_cycle: Estado=%0d Pos0=%b required 1,0", Estado, Pos0);
        end
        wait_state(3'd2, 300, n);
        total++;
        if (n !== 100 || Estado !== 3'd2) begin
            bad++;
            $display("FAIL initial_pause: extra idle cycles=%0d Estado=%0d required 100,2", n, Estado);
        end
        $display("test_reset done");
    endtask

    task automatic test_open_close();
        int n;
        int a0;
        a0 = cyc;
        clear_log();
        wait_state(3'd3, 100, n);
        total++;
        if (Estado !== 3'd3 || Regando !== 1'b1 || q_model !== 2'd3) begin
            bad++;
            $display("FAIL open_reach_rega: Estado=%0d Regando=%b Q=%0d required 3,1,3", Estado, Regando, q_model);
        end
        total++;
        if (step_cyc.size() !== 3 || step_y.size() !== 3) begin
            bad++;
            $display("FAIL open_step_count: got %0d required 3", step_cyc.size());
        end else begin
            total++;
            if (step_cyc[0] - a0 !== 8 || step_cyc[1] - step_cyc[0] !== 8 || step_cyc[2] - step_cyc[1] !== 8
                || step_y[0] !== 1'b1 || step_y[1] !== 1'b1 || step_y[2] !== 1'b1) begin
                bad++;
                $display("FAIL open_step_spacing: first=%0d gaps=%0d,%0d Y=%b%b%b required 8,8,8 Y=111",
                         step_cyc[0] - a0, step_cyc[1] - step_cyc[0], step_cyc[2] - step_cyc[1], step_y[0], step_y[1], step_y[2]);
            end
        end
        Seco = 1'b0;
        Umido = 1'b1;
        cyc1();
        total++;
        if (Estado !== 3'd4 || Y !== 1'b0 || Regando !== 1'b0) begin
            bad++;
            $display("FAIL umido_close: Estado=%0d Y=%b Regando=%b required 4,0,0", Estado, Y, Regando);
        end
        clear_log();
        wait_state(3'd1, 100, n);
        total++;
        if (Estado !== 3'd1 || q_model !== 2'd0 || step_y.size() !== 3) begin
            bad++;
            $display("FAIL close_done: Estado=%0d Q=%0d steps=%0d required 1,0,3", Estado, q_model, step_y.size());
        end else begin
            total++;
            if (step_y[0] !== 1'b0 || step_y[1] !== 1'b0 || step_y[2] !== 1'b0) begin
                bad++;
                $display("FAIL close_dir: Y=%b%b%b required 000", step_y[0], step_y[1], step_y[2]);
            end
        end
        Umido = 1'b0;
        $display("test_open_close done");
    endtask

    task automatic test_rega_timeout();
        int n;
        apply_reset();
        Seco = 1'b1;
        wait_state(3'd3, 400, n);
        wait_state(3'd4, 1200, n);
        total++;
        if (n !== 1000 || Estado !== 3'd4) begin
            bad++;
            $display("FAIL rega_length: cycles=%0d Estado=%0d required 1000,4", n, Estado);
        end
        clear_log();
        wait_state(3'd1, 100, n);
        total++;
        if (Estado !== 3'd1 || q_model !== 2'd0 || step_cyc.size() !== 3) begin
            bad++;
            $display("FAIL timeout_close: Estado=%0d Q=%0d steps=%0d required 1,0,3", Estado, q_model, step_cyc.size());
        end
        wait_state(3'd2, 300, n);
        total++;
        if (n !== 101 || Estado !== 3'd2) begin
            bad++;
            $display("FAIL pause_reopen: idle cycles=%0d Estado=%0d required 101,2", n, Estado);
        end
        Seco = 1'b0;
        $display("test_rega_timeout done");
    endtask

    task automatic test_abort();
        int n;
        apply_reset();
        Seco = 1'b1;
        wait_state(3'd2, 300, n);
        clear_log();
        n = 0;
        while (step_cyc.size() == 0 && n < 20) begin
            cyc1();
            n++;
        end
        cyc1();
        total++;
        if (q_model !== 2'd1 || Estado !== 3'd2) begin
            bad++;
            $display("FAIL abort_setup: Q=%0d Estado=%0d required 1,2", q_model, Estado);
        end
        NivelBaixo = 1'b1;
        cyc1();
        total++;
        if (Estado !== 3'd4 || Y !== 1'b0) begin
            bad++;
            $display("FAIL abort_fecha: Estado=%0d Y=%b required 4,0", Estado, Y);
        end
        wait_state(3'd1, 50, n);
        total++;
        if (Estado !== 3'd1 || q_model !== 2'd0 || step_y.size() !== 2 || Alarme !== 1'b0) begin
            bad++;
            $display("FAIL abort_done: Estado=%0d Q=%0d steps=%0d Alarme=%b required 1,0,2,0", Estado, q_model, step_y.size(), Alarme);
        end else begin
            total++;
            if (step_y[0] !== 1'b1 || step_y[1] !== 1'b0) begin
                bad++;
                $display("FAIL abort_dirs: Y=%b%b required 10", step_y[0], step_y[1]);
            end
        end
        NivelBaixo = 1'b0;
        Seco = 1'b0;
        $display("test_abort done");
    endtask

    task automatic test_fault();
        int n;
        int errs;
        stuck = 1'b1;
        apply_reset();
        Seco = 1'b1;
        wait_state(3'd2, 300, n);
        clear_log();
        wait_state(3'd5, 100, n);
        total++;
        if (Estado !== 3'd5 || step_cyc.size() !== 5 || Alarme !== 1'b1) begin
            bad++;
            $display("FAIL fault_enter: Estado=%0d steps=%0d Alarme=%b required 5,5,1", Estado, step_cyc.size(), Alarme);
        end else begin
            total++;
            if (cyc - step_cyc[4] !== 2) begin
                bad++;
                $display("FAIL fault_latency: %0d cycles after 5th Step required 2", cyc - step_cyc[4]);
            end
        end
        errs = 0;
        for (int i = 0; i < 6; i++) begin
            if (Estado !== 3'd5 || Pos0 !== 1'b1 || Step !== 1'b0 || Y !== 1'b0 || Alarme !== 1'b1) errs++;
            cyc1();
        end
        total++;
        if (errs !== 0) begin
            bad++;
            $display("FAIL alarme_hold: %0d bad cycles required 0", errs);
        end
        Seco = 1'b0;
        stuck = 1'b0;
        Rst = 1'b1;
        cyc1();
        total++;
        if (Estado !== 3'd0 || Alarme !== 1'b0 || Pos0 !== 1'b0) begin
            bad++;
            $display("FAIL fault_reset: Estado=%0d Alarme=%b Pos0=%b required 0,0,0", Estado, Alarme, Pos0);
        end
        Rst = 1'b0;
        $display("test_fault done");
    endtask

    task automatic test_conflict();
        int errs;
        apply_reset();
        Seco = 1'b1;
        Umido = 1'b1;
        cyc1();
        clear_log();
        errs = 0;
        for (int i = 0; i < 250; i++) begin
            cyc1();
            if (Estado !== 3'd1) errs++;
        end
        total++;
        if (errs !== 0 || step_cyc.size() !== 0 || Alarme !== 1'b0) begin
            bad++;
            $display("FAIL conflict_idle: non-idle=%0d steps=%0d Alarme=%b required 0,0,0", errs, step_cyc.size(), Alarme);
        end
        Seco = 1'b0;
        Umido = 1'b0;
        $display("test_conflict done");
    endtask

    initial begin
        test_reset();
        test_open_close();
        test_rega_timeout();
        test_abort();
        test_fault();
        test_conflict();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
